dm_bus_arbiter: RTL and testbench
=================================

// Module: dm_bus_arbiter
// PURPOSE
// - Shares the debug module's single bus slave port (bus_valid/ready/write/addr/wdata/rdata) among
//   NUM_REQ requesters (one per hart's debug-ROM fetch/data path, plus optional system master).
// - Round-robin, one transaction in flight; request fields are captured at grant and held to the DM until handshake.
// - Sits between hart-side debug buses and the DM; the DM sees one well-behaved master.
// PARAMETERS
// - NUM_REQ   2   number of requesters (>=1); ids 0..NUM_REQ-1
// - ADDR_W   20   bus address width (DM bus_addr)
// - TIMEOUT  64   cycles in GRANT before timeout abort (only with DM_BUS_ARB_TIMEOUT_EN); >=2
// PORTS
// - clk         in   1               clock, all logic on posedge
// - resetn      in   1               asynchronous, active-low reset
// - req_valid   in   NUM_REQ         per-requester request valid
// - req_ready   out  NUM_REQ         per-requester completion strobe (one-cycle pulse)
// - req_write   in   NUM_REQ         per-requester write flag
// - req_addr    in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
// - req_wdata   in   NUM_REQ*32      packed write data, requester i at [i*32 +: 32]
// - req_rdata   out  32              read data, broadcast; valid only with the granted req_ready pulse
// - bus_valid   out  1               to DM bus_valid
// - bus_ready   in   1               from DM bus_ready
// - bus_write   out  1               to DM bus_write
// - bus_addr    out  ADDR_W          to DM bus_addr
// - bus_wdata   out  32              to DM bus_wdata
// - bus_rdata   in   32              from DM bus_rdata
// - grant_id    out  clog2(NUM_REQ)  id of current/last granted requester (max(1,...) bits)
// - timeout_err out  1               one-cycle pulse on timeout abort
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE, bus_valid=0, bus_write=0, bus_addr=0, bus_wdata=0, req_ready=0,
//   grant_id=0, last-served pointer=NUM_REQ-1 (so requester 0 wins first), timeout_err=0, counter=0.
//   Reset mid-transaction drops bus_valid immediately; the transaction is lost, no req_ready.
// - FSM IDLE -> GRANT -> IDLE.
// - IDLE: if any req_valid, select first asserted id scanning last+1, last+2, ... (mod NUM_REQ); at the edge
//   register grant_id, bus_write/addr/wdata from that requester, enter GRANT. No request: stay IDLE.
// - GRANT: bus_valid=1 (registered, driven from state), fields held constant; req_valid changes ignored.
// - Handshake: cycle with bus_valid && bus_ready -> req_ready[grant_id]=1 combinationally that cycle,
//   req_rdata=bus_rdata (reads; 0 is acceptable content on writes); next edge: state=IDLE, bus_valid=0,
//   last=grant_id. All other req_ready bits 0 always.
// - Latency: req_valid seen in cycle n -> bus_valid in n+1 -> DM bus_ready earliest n+2 -> req_ready n+2.
//   Back-to-back: one IDLE cycle between transactions (next grant registered at end of IDLE cycle).
// - Requester must hold req_valid and fields until its req_ready; it must drop/refresh req_valid in the cycle
//   after req_ready, else it is re-arbitrated as a new request.
// - Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...
// - Simultaneous: new req_valid during GRANT waits; only IDLE arbitrates. NUM_REQ=1: always grants id 0.
// - req_rdata = bus_rdata whenever no pulse is active (don't-care content).
// CONFIGURATION
// - DM_BUS_ARB_TIMEOUT_EN defined: counter clears on GRANT entry, increments each GRANT cycle without
//   handshake; when it reaches TIMEOUT-1 without bus_ready: req_ready[grant_id]=1, req_rdata=32'h0,
//   timeout_err=1 that cycle, state->IDLE, last=grant_id. Handshake in that same cycle wins (normal completion,
//   no timeout_err).
// - Not defined: no counter; GRANT waits indefinitely; timeout_err tied 0.
// TESTING
// - Reset: resetn=0 mid-GRANT -> bus_valid=0, req_ready=0 immediately; after release first grant goes to id 0.
// - Single read: req0 read addr 20'h00300 -> bus_valid cycle n+1 with bus_addr 20'h00300, DM ready, returns
//   32'h12345678 -> req_ready[0] pulse with req_rdata=32'h12345678.
// - Write: req1 write addr 20'h00400 wdata 32'hA5A5A5A5 -> bus_write=1, bus_wdata=32'hA5A5A5A5 held until ready.
// - Round robin: NUM_REQ=3, all valid continuously for 6 transactions -> grant_id order 0,1,2,0,1,2.
// - Hold: req0 granted, req1 asserts and req0 changes addr during GRANT -> bus_addr unchanged, req1 served next.
// - Timeout (macro on, TIMEOUT=8): DM never ready -> req_ready pulse + timeout_err in 8th GRANT cycle, rdata=0.

Source files
------------

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter
// Shares the debug module's single bus slave port among NUM_REQ requesters.
// Arbitration is round-robin, and only one transaction is in flight at a time.
// The winner's write/addr/wdata fields are captured at grant and held on the
// DM bus until the handshake completes.
//
// Ports:
//   clk, resetn             clock (posedge) and asynchronous active-low reset
//   req_valid/req_ready     per-requester request / one-cycle completion strobe
//   req_write/addr/wdata    packed per-requester fields; requester i sits at slice i
//   req_rdata               read data broadcast to all requesters
//   bus_*                   master side of the DM bus
//   grant_id                id of the current or last granted requester
//   timeout_err             one-cycle pulse when a stalled transaction is aborted
//
// Optional feature: define DM_BUS_ARB_TIMEOUT_EN to abort a transaction that
// has spent TIMEOUT cycles in GRANT without bus_ready. The aborted request
// completes with zero read data and a timeout_err pulse.
//
// state   | meaning
// S_IDLE  | no transaction; arbitrate among req_valid
// S_GRANT | fields captured, bus_valid asserted, waiting for bus_ready
module dm_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [31:0]               req_rdata,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic                      bus_write,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [31:0]               bus_wdata,
  input  logic [31:0]               bus_rdata,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                      timeout_err
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t            state;
  logic [GW-1:0]     last_id;
  logic              any_req;
  logic [GW-1:0]     sel_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              hs;
  logic              abort;
  logic              done;

  // Rotating priority: each requester's distance from last_id+1 (mod
  // NUM_REQ) is its rank, and the lowest-ranked valid requester wins. This
  // keeps every vector index a loop constant.
  always_comb begin
    int best_d;
    int d;
    best_d    = NUM_REQ;
    d         = 0;
    any_req   = 1'b0;
    sel_id    = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        d = (i + 2 * NUM_REQ - int'(last_id) - 1) % NUM_REQ;
        if (d < best_d) begin
          best_d    = d;
          any_req   = 1'b1;
          sel_id    = GW'(i);
          sel_write = req_write[i];
          sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
          sel_wdata = req_wdata[i*32 +: 32];
        end
      end
    end
  end

  assign hs = bus_valid & bus_ready;

`ifdef DM_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  // Down-counter, loaded on grant entry; terminal count 0 marks the
  // TIMEOUT-th GRANT cycle.
  logic [CW-1:0] tmr;
  assign abort = bus_valid & ~bus_ready & (tmr == '0);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign abort = 1'b0;
`endif

  assign done        = hs | abort;
  assign timeout_err = abort;
  assign req_rdata   = abort ? 32'h0 : bus_rdata;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = done && (grant_id == GW'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      bus_valid <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      grant_id  <= '0;
      last_id   <= GW'(NUM_REQ - 1);
`ifdef DM_BUS_ARB_TIMEOUT_EN
      tmr       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state     <= S_GRANT;
            bus_valid <= 1'b1;
            grant_id  <= sel_id;
            bus_write <= sel_write;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
`ifdef DM_BUS_ARB_TIMEOUT_EN
            tmr       <= CW'(TIMEOUT - 1);
`endif
          end
        end
        S_GRANT: begin
          if (done) begin
            state     <= S_IDLE;
            bus_valid <= 1'b0;
            last_id   <= grant_id;
          end
`ifdef DM_BUS_ARB_TIMEOUT_EN
          else begin
            tmr <= tmr - 1'b1;
          end
`endif
        end
        default: begin
          state     <= S_IDLE;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
module tb_dm_bus_arbiter;

  localparam int NR = 3;
  localparam int AW = 20;
  localparam int TO = 8;
`ifdef DM_BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk;
  logic              resetn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*32-1:0]  req_wdata;
  logic [31:0]       req_rdata;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_write;
  logic [AW-1:0]     bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic [1:0]        grant_id;
  logic              timeout_err;

  dm_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Requester intentions and DM behaviour for the coming cycle.
  logic          act [NR];
  logic          wr  [NR];
  logic [AW-1:0] ad  [NR];
  logic [31:0]   wd  [NR];
  logic          rdy;
  logic [31:0]   rdat;

  // Transaction-level reference: one outstanding grant, rotating pointer.
  bit            m_busy;
  int            m_gid;
  int            m_last;
  int            m_cyc;
  logic          m_wr;
  logic [AW-1:0] m_ad;
  logic [31:0]   m_wd;

  int n_chk;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_last = NR - 1; m_cyc = 0;
    for (int i = 0; i < NR; i++) act[i] = 1'b0;
    rdy = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check_eq("rst_bus_valid", bus_valid, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_write", bus_write, 0);
    check_eq("rst_bus_wdata", bus_wdata, 0);
    model_reset();
    req_valid = '0;
    bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // One clock cycle: apply inputs after the edge, check at the falling edge,
  // then advance the reference across the next rising edge.
  task automatic run_cycle();
    logic hs, to;
    logic [NR-1:0] er;
    bit found;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = act[i];
      req_write[i] = wr[i];
      req_addr[i*AW +: AW] = ad[i];
      req_wdata[i*32 +: 32] = wd[i];
    end
    bus_ready = rdy;
    bus_rdata = rdat;
    @(negedge clk);
    hs = m_busy && rdy;
    to = TO_EN && m_busy && !rdy && (m_cyc == TO);
    check_eq("bus_valid", bus_valid, m_busy);
    check_eq("grant_id", grant_id, m_gid);
    if (m_busy) begin
      check_eq("bus_addr", bus_addr, m_ad);
      check_eq("bus_write", bus_write, m_wr);
      check_eq("bus_wdata", bus_wdata, m_wd);
    end
    er = '0;
    if (hs || to) er[m_gid] = 1'b1;
    check_eq("req_ready", req_ready, er);
    if (hs) check_eq("req_rdata", req_rdata, rdat);
    if (to) check_eq("req_rdata_to", req_rdata, 0);
    check_eq("timeout_err", timeout_err, to);
    if (hs || to) begin
      m_busy = 0;
      m_last = m_gid;
      act[m_gid] = 1'b0;
    end else if (m_busy) begin
      m_cyc++;
    end else begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && act[(m_last + k) % NR]) begin
          found = 1;
          m_gid = (m_last + k) % NR;
        end
      end
      if (found) begin
        m_busy = 1; m_cyc = 1;
        m_wr = wr[m_gid]; m_ad = ad[m_gid]; m_wd = wd[m_gid];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, cnt;
    bit prev_v, hit;
    clk = 1'b0; resetn = 1'b0;
    n_chk = 0; n_fail = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0; rdat = '0;
    for (int i = 0; i < NR; i++) begin
      act[i] = 0; wr[i] = 0; ad[i] = '0; wd[i] = '0;
    end
    model_reset();
    #12;
    do_reset();

    // single read from requester 0
    act[0] = 1; wr[0] = 0; ad[0] = 20'h00300; wd[0] = 32'h0;
    rdy = 0; rdat = 32'hDEAD0000;
    run_cycle();
    check_eq("rd_no_valid_yet", bus_valid, 0);
    run_cycle();
    check_eq("rd_addr", bus_addr, 20'h00300);
    rdy = 1; rdat = 32'h12345678;
    run_cycle();
    check_eq("rd_ready0", req_ready, 3'b001);
    check_eq("rd_rdata", req_rdata, 32'h12345678);
    rdy = 0;
    run_cycle();

    // write from requester 1, held until ready
    act[1] = 1; wr[1] = 1; ad[1] = 20'h00400; wd[1] = 32'hA5A5A5A5;
    repeat (4) run_cycle();
    check_eq("wr_write", bus_write, 1);
    check_eq("wr_wdata", bus_wdata, 32'hA5A5A5A5);
    check_eq("wr_addr", bus_addr, 20'h00400);
    rdy = 1;
    run_cycle();
    check_eq("wr_ready1", req_ready, 3'b010);
    rdy = 0;
    run_cycle();

    // round robin with all requesters continuously valid
    do_reset();
    rdy = 1; k = 0; prev_v = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      for (int i = 0; i < NR; i++) begin
        act[i] = 1; wr[i] = $urandom_range(0, 1); ad[i] = AW'($urandom); wd[i] = $urandom;
      end
      run_cycle();
      if (bus_valid && !prev_v) begin
        check_eq("rr_order", grant_id, k % NR);
        k++;
      end
      prev_v = bus_valid;
    end
    check_eq("rr_count", k, 6);

    // hold: fields frozen during GRANT, new request waits
    do_reset();
    act[0] = 1; wr[0] = 0; ad[0] = 20'h00111; wd[0] = 32'h1;
    run_cycle();
    act[1] = 1; wr[1] = 0; ad[1] = 20'h00222; wd[1] = 32'h2;
    ad[0] = 20'h00999;
    run_cycle();
    run_cycle();
    check_eq("hold_addr", bus_addr, 20'h00111);
    rdy = 1;
    run_cycle();
    rdy = 0;
    run_cycle();
    run_cycle();
    check_eq("hold_next_gid", grant_id, 1);
    check_eq("hold_next_addr", bus_addr, 20'h00222);

    // reset in the middle of GRANT
    rdy = 1;
    run_cycle();
    do_reset();
    act[1] = 1; wr[1] = 0; ad[1] = 20'h00501;
    run_cycle();
    run_cycle();
    bus_ready = 1'b1;
    #1;
    check_eq("pre_rst_ready", req_ready, 3'b010);
    do_reset();
    act[0] = 1; ad[0] = 20'h00600; act[1] = 1; ad[1] = 20'h00601;
    run_cycle();
    run_cycle();
    check_eq("rst_first_gid", grant_id, 0);
    check_eq("rst_first_addr", bus_addr, 20'h00600);

    // stalled DM
    do_reset();
    act[2] = 1; wr[2] = 0; ad[2] = 20'h00777;
    rdy = 0; rdat = 32'hFFFFFFFF; cnt = 0; hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      run_cycle();
      if (bus_valid) cnt++;
      if (timeout_err) begin
        hit = 1;
        check_eq("to_rdata", req_rdata, 0);
        check_eq("to_ready", req_ready, 3'b100);
      end
    end
`ifdef DM_BUS_ARB_TIMEOUT_EN
    check_eq("to_cycles", cnt, TO);
`else
    check_eq("no_to_still_valid", bus_valid, 1);
    rdy = 1;
    run_cycle();
`endif
    rdy = 0;
    run_cycle();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i] = 1; wr[i] = $urandom_range(0, 1);
          ad[i] = AW'($urandom); wd[i] = $urandom;
        end
      end
      if (m_busy && $urandom_range(0, 4) == 0) ad[m_gid] = AW'($urandom);
      rdy = m_busy ? ($urandom_range(0, 99) < 35) : 1'($urandom_range(0, 1));
      rdat = $urandom;
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
